mult_div_unit: RTL
==================

# mult_div_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline, owning the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and models multi-cycle latency with a `busy` flag. The hazard/forwarding unit combines `busy` with `start` to stall MDU-dependent instructions in D. `hi` and `lo` feed the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu (and madd/maddu).
- `DIV_CYCLES`, default 10: busy duration for div/divu.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  a valid MDU instruction is in E this cycle. Bubbles inserted by the hazard unit have `start=0`.
- `op`  in  3  operation code, defined in `mdu_defs.vh`.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `busy`  out  1  a mult/div is in progress.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE.
  - RUN: `cnt` counts down; `pend_hi`/`pend_lo` hold the pending result.
- IDLE with `start=1` and op mult/multu/div/divu:
  - Compute the 64-bit result from `a`,`b` at this edge and store it in `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES` and go to RUN.
- IDLE with `start=1` and op mthi/mtlo: write `a` to HI or LO at this edge; stay in IDLE.
- RUN: `cnt` decrements each cycle. At the edge where `cnt==1`:
  - commit `pend_hi`/`pend_lo` to HI/LO;
  - go to IDLE, so `busy` falls.
- `start` while RUN is ignored for every op, including mthi/mtlo. The hazard unit must prevent this; the bench checks that HI/LO and the pending result are unaffected.
- mult: signed 32×32→64, with `{hi,lo}` = product.
- multu: unsigned 32×32→64, with `{hi,lo}` = product.
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`b==0`): still goes busy for `DIV_CYCLES`, but commits nothing; HI/LO keep their old values.
- Undefined op codes with `start=1`: no effect.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, pending result = 0.
- Reset mid-operation aborts immediately; no later commit occurs.
- Start sampled at edge t0:
  - `busy`=1 during cycles t0+1 … t0+N;
  - HI/LO updated at edge t0+N;
  - `busy`=0 after edge t0+N.
- `busy` is 0 in the cycle `start` is presented. The hazard unit therefore stalls D on `start|busy`.
- mthi/mtlo take effect at edge t0, with zero busy cycles. mfhi in the next cycle sees the new value.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Configuration
- `MDU_MADD_EN` defined:
  - op codes madd (signed) and maddu (unsigned) are enabled;
  - the pending result is `{HI,LO}` + product, using HI/LO as sampled at start;
  - latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: those op codes behave as undefined (no effect, no busy).

## Structure
- `mdu_defs.vh` holds the op encodings, shared with the controller and the hazard unit:
  - `MDU_MULT`=0, `MDU_MULTU`=1, `MDU_DIV`=2, `MDU_DIVU`=3;
  - `MDU_MTHI`=4, `MDU_MTLO`=5;
  - `MDU_MADD`=6, `MDU_MADDU`=7.
- Sub-module `mdu_arith`: purely combinational. It takes `op`, `a`, `b` and the current HI/LO, and returns the 64-bit result plus a `div_zero` flag.
- Top level holds the state, counter, pending registers and HI/LO.

## Test plan
- mult a=0xFFFFFFFF, b=2 → `busy` high for cycles 1–5; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 after mthi 0x11 / mtlo 0x22 → 10 busy cycles; hi=0x11, lo=0x22 unchanged.
- mtlo 0xAB issued while RUN (mult 3×4 in flight) → ignored; final lo=12, hi=0.
- div 100/7 started, then `rst_n` low at cycle 3 → `busy`=0, hi=lo=0 immediately; still 0 fifteen cycles later.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, helpers.
// Op encodings match mdu_defs.vh used by the controller and hazard unit.
package mult_div_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the MDU: 64-bit product/quotient-remainder result and divide-by-zero flag.
// madd/maddu accumulation into {hi,lo} is present only when MDU_MADD_EN is defined.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_zero,
  output logic        launch_op,
  output logic        is_div
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdsor_s;
  logic [31:0] udsor_s;
  logic [31:0] squot_mag_s;
  logic [31:0] srem_mag_s;
  logic [31:0] squot_s;
  logic [31:0] srem_s;
  logic [31:0] uquot_s;
  logic [31:0] urem_s;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 needs no special overflow handling.
  always_comb begin
    abs_a_s = a;
    abs_b_s = b;
    if (a[31]) begin
      abs_a_s = neg32(a);
    end else begin
      abs_a_s = a;
    end
    if (b[31]) begin
      abs_b_s = neg32(b);
    end else begin
      abs_b_s = b;
    end
    // A zero divisor is replaced by 1 only to keep the datapath defined; the result is discarded.
    if (b == 32'd0) begin
      sdsor_s = 32'd1;
      udsor_s = 32'd1;
    end else begin
      sdsor_s = abs_b_s;
      udsor_s = b;
    end
    squot_mag_s = abs_a_s / sdsor_s;
    srem_mag_s  = abs_a_s % sdsor_s;
    uquot_s     = a / udsor_s;
    urem_s      = a % udsor_s;
    if (a[31] ^ b[31]) begin
      squot_s = neg32(squot_mag_s);
    end else begin
      squot_s = squot_mag_s;
    end
    if (a[31]) begin
      srem_s = neg32(srem_mag_s);
    end else begin
      srem_s = srem_mag_s;
    end
  end

  // Result select by op; only multi-cycle ops raise launch_op.
  always_comb begin
    result    = 64'd0;
    div_zero  = 1'b0;
    launch_op = 1'b0;
    is_div    = 1'b0;
    case (op)
      MDU_MULT: begin
        result    = prod_s_s;
        launch_op = 1'b1;
      end
      MDU_MULTU: begin
        result    = prod_u_s;
        launch_op = 1'b1;
      end
      MDU_DIV: begin
        result    = {srem_s, squot_s};
        div_zero  = (b == 32'd0);
        launch_op = 1'b1;
        is_div    = 1'b1;
      end
      MDU_DIVU: begin
        result    = {urem_s, uquot_s};
        div_zero  = (b == 32'd0);
        launch_op = 1'b1;
        is_div    = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        result    = {hi, lo} + prod_s_s;
        launch_op = 1'b1;
      end
      MDU_MADDU: begin
        result    = {hi, lo} + prod_u_s;
        launch_op = 1'b1;
      end
`endif
      default: begin
        result    = 64'd0;
        launch_op = 1'b0;
      end
    endcase
  end

`ifndef MDU_MADD_EN
  logic unused_hilo_s;
  assign unused_hilo_s = ^{hi, lo};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; models multi-cycle latency with busy.
// Optional feature macro: MDU_MADD_EN enables madd/maddu (accumulate into {HI,LO}).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  mdu_state_e       state_r;
  mdu_state_e       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_ok_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;

  logic [63:0]      result_s;
  logic             div_zero_s;
  logic             launch_op_s;
  logic             is_div_s;
  logic             launch_s;
  logic             commit_s;
  logic             last_s;
  logic             wr_hi_s;
  logic             wr_lo_s;

  mdu_arith u_arith (
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi_r),
    .lo        (lo_r),
    .result    (result_s),
    .div_zero  (div_zero_s),
    .launch_op (launch_op_s),
    .is_div    (is_div_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: a launch enters RUN, the last count returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && launch_op_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_ONE) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Datapath controls; every start seen in RUN is dropped here.
  always_comb begin
    launch_s = 1'b0;
    last_s   = 1'b0;
    wr_hi_s  = 1'b0;
    wr_lo_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        launch_s = start && launch_op_s;
        wr_hi_s  = start && (op == MDU_MTHI);
        wr_lo_s  = start && (op == MDU_MTLO);
      end
      ST_RUN: begin
        last_s = (cnt_r == CNT_ONE);
      end
      default: begin
        launch_s = 1'b0;
      end
    endcase
    commit_s = last_s && pend_ok_r;
  end

  // Counter, pending result, HI/LO and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_ok_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (next_state_s == ST_RUN);
      if (launch_s) begin
        pend_hi_r <= result_s[63:32];
        pend_lo_r <= result_s[31:0];
        pend_ok_r <= !div_zero_s;
        cnt_r     <= is_div_s ? DIV_CNT : MULT_CNT;
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
      if (commit_s) begin
        hi_r <= pend_hi_r;
      end else if (wr_hi_s) begin
        hi_r <= a;
      end
      if (commit_s) begin
        lo_r <= pend_lo_r;
      end else if (wr_lo_s) begin
        lo_r <= a;
      end
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
